decoder_8b10b: RTL and testbench

//   Receive-side 8b/10b decoder (IEEE 802.3 cl.36 tables) for the chiplet link PHY.

---
 rtl/decoder_8b10b_if.sv | 24 ++
 rtl/decoder_8b10b.sv | 154 +++++++++++++++
 tb/tb_decoder_8b10b.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_8b10b_if.sv
// Symbol-in / byte-out bundle between the deserializer side and the 8b/10b decoder.
// master drives symbols and observes results; slave is the decoder.
interface decoder_8b10b_if;
    // A symbol is taken on every rising clk edge where enable is high; there is no
    // backpressure. valid_out marks the single cycle carrying that symbol's result.
    logic       enable;
    logic [9:0] encoded;
    logic [7:0] data_out;
    logic       k_out;
    logic       valid_out;
    logic       code_err;
    logic       disp_err;
    logic       rd_out;

    modport master (
        output enable, encoded,
        input  data_out, k_out, valid_out, code_err, disp_err, rd_out
    );

    modport slave (
        input  enable, encoded,
        output data_out, k_out, valid_out, code_err, disp_err, rd_out
    );
endinterface

// File: rtl/decoder_8b10b.sv
// Receive-side 8b/10b decoder: table lookup of the 6b and 4b sub-blocks, running
// disparity tracking, and code/disparity error flags, all behind one register stage.
module decoder_8b10b (
    input  logic           clk,
    input  logic           n_rst,
    decoder_8b10b_if.slave bus
);
    logic [7:0] data_q, data_d;
    logic       k_q, k_d;
    logic       valid_q, valid_d;
    logic       code_err_q, code_err_d;
    logic       disp_err_q, disp_err_d;
    logic       rd_q, rd_d;

    logic [5:0] sub6;
    logic [3:0] sub4;
    logic [3:0] sub4_eff;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic       ok6, ok4, is_k28, is_kx7;
    logic [2:0] ones6, ones4;
    logic       pos6, neg6, pos4, neg4;
    logic       err6, err4, rd_mid, rd_next;

    assign sub6 = bus.encoded[9:4];
    assign sub4 = bus.encoded[3:0];

    // 5b/6b lookup, both disparity forms of each code
    always_comb begin
        edcba  = 5'd0;
        ok6    = 1'b1;
        is_k28 = 1'b0;
        case (sub6)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            6'b001111, 6'b110000: begin
                edcba  = 5'd28;
                is_k28 = 1'b1;
            end
            default:              ok6 = 1'b0;
        endcase
    end

    // The RD+ form of K28.y is the bitwise complement of the RD- form, so its 4b
    // half is inverted before the shared 3b/4b lookup.
    assign sub4_eff = (sub6 == 6'b110000) ? ~sub4 : sub4;

    always_comb begin
        hgf = 3'd0;
        ok4 = 1'b1;
        case (sub4_eff)
            4'b1011, 4'b0100:                   hgf = 3'd0;
            4'b1001:                            hgf = 3'd1;
            4'b0101:                            hgf = 3'd2;
            4'b1100, 4'b0011:                   hgf = 3'd3;
            4'b1101, 4'b0010:                   hgf = 3'd4;
            4'b1010:                            hgf = 3'd5;
            4'b0110:                            hgf = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
            default:                            ok4 = 1'b0;
        endcase
    end

    // K23/27/29/30.7 differ from the D.x.7 data codes only by the alternate 4b form
    assign is_kx7 = ok6 && !is_k28
                    && (edcba == 5'd23 || edcba == 5'd27 || edcba == 5'd29 || edcba == 5'd30)
                    && (sub4 == 4'b0111 || sub4 == 4'b1000);

    assign ones6 = 3'($countones(sub6));
    assign ones4 = 3'($countones(sub4));
    assign pos6  = ones6 > 3'd3;
    assign neg6  = ones6 < 3'd3;
    assign pos4  = ones4 > 3'd2;
    assign neg4  = ones4 < 3'd2;

    assign err6 = (pos6 && rd_q) || (neg6 && !rd_q)
                  || (sub6 == 6'b111000 && rd_q) || (sub6 == 6'b000111 && !rd_q);
    assign rd_mid = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_q);

    assign err4 = (pos4 && rd_mid) || (neg4 && !rd_mid)
                  || (sub4 == 4'b1100 && rd_mid) || (sub4 == 4'b0011 && !rd_mid);
    assign rd_next = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid);

    always_comb begin
        data_d     = data_q;
        k_d        = k_q;
        code_err_d = code_err_q;
        disp_err_d = disp_err_q;
        rd_d       = rd_q;
        valid_d    = bus.enable;
        if (bus.enable) begin
            code_err_d = !(ok6 && ok4);
            disp_err_d = err6 || err4;
            rd_d       = rd_next;
            data_d     = (ok6 && ok4) ? {hgf, edcba} : 8'h00;
            k_d        = (ok6 && ok4) && (is_k28 || is_kx7);
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            data_q     <= 8'h00;
            k_q        <= 1'b0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            disp_err_q <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            data_q     <= data_d;
            k_q        <= k_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            disp_err_q <= disp_err_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.k_out     = k_q;
    assign bus.valid_out = valid_q;
    assign bus.code_err  = code_err_q;
    assign bus.disp_err  = disp_err_q;
    assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_decoder_8b10b.sv
// Directed-vector bench for decoder_8b10b; each observation packs
// {valid_out, data_out, k_out, code_err, disp_err, rd_out} into 13 bits.
module tb_decoder_8b10b;
    logic clk;
    logic n_rst;
    int   n_vec;
    int   n_err;

    decoder_8b10b_if dif();

    decoder_8b10b dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (dif)
    );

    logic [12:0] obs;
    assign obs = {dif.valid_out, dif.data_out, dif.k_out, dif.code_err, dif.disp_err, dif.rd_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] sym);
        @(negedge clk);
        dif.enable  = 1'b1;
        dif.encoded = sym;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        dif.enable  = 1'b0;
        dif.encoded = 10'h3FF;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        dif.enable = 1'b0;
        n_rst      = 1'b1;
        @(negedge clk);
        n_rst      = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        exp = 13'h0000;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_state got %h want %h", obs, exp);
        end
        @(negedge clk);
        n_rst = 1'b0;
        drive(10'b1010101010);
        exp = {1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d21_5 got %h want %h", obs, exp);
        end
    endtask

    task automatic test_hold();
        logic [12:0] exp;
        idle();
        exp = {1'b0, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL hold_when_idle got %h want %h", obs, exp);
        end
    endtask

    task automatic test_k28_5();
        logic [12:0] exp;
        drive(10'b0011111010);
        exp = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL k28_5_rdm got %h want %h", obs, exp);
        end
        drive(10'b1100000101);
        exp = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL k28_5_rdp got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_d0_0();
        logic [12:0] exp;
        drive(10'b1001110100);
        exp = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d0_0 got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_disp_after_reset();
        logic [12:0] exp;
        do_reset();
        drive(10'b1100000101);
        exp = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL disp_after_reset got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_illegal();
        logic [10:0] exp;
        do_reset();
        drive(10'b1111111111);
        exp = {1'b1, 8'h00, 1'b0, 1'b1};
        n_vec++;
        if (obs[12:2] !== exp) begin
            n_err++;
            $display("FAIL illegal_ones got %h want %h", obs[12:2], exp);
        end
        do_reset();
        drive(10'b0000000000);
        n_vec++;
        if (obs[12:2] !== exp) begin
            n_err++;
            $display("FAIL illegal_zeros got %h want %h", obs[12:2], exp);
        end
        idle();
    endtask

    task automatic test_special_neutrals();
        logic [12:0] exp;
        do_reset();
        // 000111 is the RD+ form of D7, so it is a disparity error at RD-
        drive(10'b0001111001);
        exp = {1'b1, 8'h27, 1'b0, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d7_1_wrong_rd got %h want %h", obs, exp);
        end
        drive(10'b1110001110);
        exp = {1'b1, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d7_7_rdm got %h want %h", obs, exp);
        end
        drive(10'b1010101100);
        exp = {1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d21_3_1100_at_rdp got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_k_x7();
        logic [12:0] exp;
        do_reset();
        drive(10'b1110101000);
        exp = {1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL k23_7 got %h want %h", obs, exp);
        end
        drive(10'b1110100001);
        exp = {1'b1, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL d23_7 got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_invalid_6b();
        logic [12:0] exp;
        do_reset();
        drive(10'b1111001001);
        exp = {1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL invalid_6b got %h want %h", obs, exp);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        do_reset();
        drive(10'b0011111010);
        exp = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_first got %h want %h", obs, exp);
        end
        drive(10'b1010101010);
        exp = {1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b1};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_second got %h want %h", obs, exp);
        end
        #1;
        n_rst = 1'b1;
        #1;
        exp = 13'h0000;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_async_clear got %h want %h", obs, exp);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_held_in_reset got %h want %h", obs, exp);
        end
        @(negedge clk);
        n_rst = 1'b0;
        drive(10'b1100000101);
        exp = {1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_rd_after_reset got %h want %h", obs, exp);
        end
        idle();
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        n_rst       = 1'b0;
        dif.enable  = 1'b0;
        dif.encoded = 10'h000;
        test_reset();
        test_hold();
        test_k28_5();
        test_d0_0();
        test_disp_after_reset();
        test_illegal();
        test_special_neutrals();
        test_k_x7();
        test_invalid_6b();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
